// File: rtl/ras_predictor.sv
// N-wide speculative return address stack for the fetch stage.
// Ports: clock/reset (async, active-low), per-slot fetch_valid/push_en/
//   pop_en/push_addr in, per-slot pred_valid/pred_target and
//   ckpt_ptr/ckpt_cnt/ckpt_top out, recover_en/ptr/cnt/top from EX.
module ras_predictor #(
  parameter int N     = 3,
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N-1:0]              fetch_valid,
  input  logic [N-1:0]              push_en,
  input  logic [N-1:0]              pop_en,
  input  logic [N-1:0][XLEN-1:0]    push_addr,
  output logic [N-1:0]              pred_valid,
  output logic [N-1:0][XLEN-1:0]    pred_target,
  output logic [N-1:0][PTR_W-1:0]   ckpt_ptr,
  output logic [N-1:0][CNT_W-1:0]   ckpt_cnt,
  output logic [N-1:0][XLEN-1:0]    ckpt_top,
  input  logic                      recover_en,
  input  logic [PTR_W-1:0]          recover_ptr,
  input  logic [CNT_W-1:0]          recover_cnt,
  input  logic [XLEN-1:0]           recover_top
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] P1   = PTR_W'(1);
  localparam logic [CNT_W-1:0] C1   = CNT_W'(1);

  logic [DEPTH-1:0][XLEN-1:0] stk_q, stk_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  // Slots are chained through ptr_d/cnt_d/stk_d so later slots see
  // the effect of earlier ones in the same bundle.
  always_comb begin
    stk_d       = stk_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    pred_valid  = '0;
    pred_target = '0;
    ckpt_ptr    = '0;
    ckpt_cnt    = '0;
    ckpt_top    = '0;
    for (int i = 0; i < N; i++) begin
      if (fetch_valid[i] && pop_en[i] && (cnt_d != '0)) begin
        pred_valid[i]  = 1'b1;
        pred_target[i] = stk_d[ptr_d];
        ptr_d          = ptr_d - P1;
        cnt_d          = cnt_d - C1;
      end
      if (fetch_valid[i] && push_en[i]) begin
        ptr_d        = ptr_d + P1;
        stk_d[ptr_d] = push_addr[i];
        // Full stack: oldest entry is overwritten by wrap-around.
        if (cnt_d != FULL)
          cnt_d = cnt_d + C1;
      end
      ckpt_ptr[i] = ptr_d;
      ckpt_cnt[i] = cnt_d;
      ckpt_top[i] = stk_d[ptr_d];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stk_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (recover_en) begin
      ptr_q              <= recover_ptr;
      cnt_q              <= recover_cnt;
      stk_q[recover_ptr] <= recover_top;
    end else begin
      stk_q <= stk_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ras_predictor.sv
// Scoreboard bench for ras_predictor: expectations are queued as
// stimulus is driven and compared when outputs settle.
module tb_ras_predictor;

  localparam int N = 3;
  localparam int DEPTH = 16;
  localparam int XLEN = 32;
  localparam int PTR_W = 4;
  localparam int CNT_W = 5;

  localparam int K_PV = 0;
  localparam int K_PT = 1;
  localparam int K_CP = 2;
  localparam int K_CC = 3;
  localparam int K_CT = 4;

  logic                     clock;
  logic                     reset;
  logic [N-1:0]             fetch_valid;
  logic [N-1:0]             push_en;
  logic [N-1:0]             pop_en;
  logic [N-1:0][XLEN-1:0]   push_addr;
  logic [N-1:0]             pred_valid;
  logic [N-1:0][XLEN-1:0]   pred_target;
  logic [N-1:0][PTR_W-1:0]  ckpt_ptr;
  logic [N-1:0][CNT_W-1:0]  ckpt_cnt;
  logic [N-1:0][XLEN-1:0]   ckpt_top;
  logic                     recover_en;
  logic [PTR_W-1:0]         recover_ptr;
  logic [CNT_W-1:0]         recover_cnt;
  logic [XLEN-1:0]          recover_top;

  ras_predictor #(
    .N(N), .DEPTH(DEPTH), .XLEN(XLEN),
    .PTR_W(PTR_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .push_en(push_en),
    .pop_en(pop_en), .push_addr(push_addr),
    .pred_valid(pred_valid), .pred_target(pred_target),
    .ckpt_ptr(ckpt_ptr), .ckpt_cnt(ckpt_cnt),
    .ckpt_top(ckpt_top), .recover_en(recover_en),
    .recover_ptr(recover_ptr), .recover_cnt(recover_cnt),
    .recover_top(recover_top)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    int          kind;
    int          slot;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int kind,
                                      input int s);
    logic [31:0] r;
    r = '0;
    case (kind)
      K_PV: r = 32'(pred_valid[s]);
      K_PT: r = pred_target[s];
      K_CP: r = 32'(ckpt_ptr[s]);
      K_CC: r = 32'(ckpt_cnt[s]);
      K_CT: r = ckpt_top[s];
      default: r = 'x;
    endcase
    return r;
  endfunction

  task automatic ex(input string tag, input int kind,
                    input int s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.slot = s; e.val = v;
    sb.push_back(e);
  endtask

  task automatic idle();
    fetch_valid = '0;
    push_en     = '0;
    pop_en      = '0;
    push_addr   = '0;
    recover_en  = 1'b0;
    recover_ptr = '0;
    recover_cnt = '0;
    recover_top = '0;
  endtask

  task automatic drive(input logic [2:0] fv,
                       input logic [2:0] pu,
                       input logic [2:0] po,
                       input logic [31:0] a0,
                       input logic [31:0] a1,
                       input logic [31:0] a2);
    fetch_valid  = fv;
    push_en      = pu;
    pop_en       = po;
    push_addr[0] = a0;
    push_addr[1] = a1;
    push_addr[2] = a2;
  endtask

  // Compare every queued expectation, then advance one clock.
  task automatic step();
    exp_t e;
    @(negedge clock);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.kind, e.slot), e.val);
    end
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #3;
    for (int s = 0; s < N; s++) begin
      ex("rst_pv", K_PV, s, 0);
      ex("rst_pt", K_PT, s, 0);
      ex("rst_cp", K_CP, s, 0);
      ex("rst_cc", K_CC, s, 0);
      ex("rst_ct", K_CT, s, 0);
    end
    step();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();

    // single push then pop, then underflow
    drive(3'b010, 3'b010, 3'b000, 0, 32'h8, 0);
    ex("t1_cc0", K_CC, 0, 0);
    ex("t1_cp1", K_CP, 1, 1);
    ex("t1_cc1", K_CC, 1, 1);
    ex("t1_ct1", K_CT, 1, 32'h8);
    step();
    drive(3'b001, 3'b000, 3'b001, 0, 0, 0);
    ex("t1_pv", K_PV, 0, 1);
    ex("t1_pt", K_PT, 0, 32'h8);
    ex("t1_cnt", K_CC, 0, 0);
    step();
    drive(3'b001, 3'b000, 3'b001, 0, 0, 0);
    ex("t1_upv", K_PV, 0, 0);
    ex("t1_upt", K_PT, 0, 0);
    step();

    // in-bundle forwarding: push, pop, underflow pop
    drive(3'b111, 3'b001, 3'b110, 32'h14, 0, 0);
    ex("t2_pv0", K_PV, 0, 0);
    ex("t2_pv1", K_PV, 1, 1);
    ex("t2_pt1", K_PT, 1, 32'h14);
    ex("t2_pv2", K_PV, 2, 0);
    ex("t2_cc2", K_CC, 2, 0);
    ex("t2_cp2", K_CP, 2, 0);
    step();

    // overflow wrap and saturation
    do_reset();
    for (int k = 0; k < DEPTH + 2; k++) begin
      drive(3'b001, 3'b001, 3'b000, 32'h100 + 32'(4 * k), 0, 0);
      ex("t3_pcc", K_CC, 0, (k + 1 < DEPTH) ? k + 1 : DEPTH);
      ex("t3_pcp", K_CP, 0, (k + 1) % DEPTH);
      step();
    end
    for (int j = 0; j < DEPTH; j++) begin
      drive(3'b001, 3'b000, 3'b001, 0, 0, 0);
      ex("t3_pv", K_PV, 0, 1);
      ex("t3_pt", K_PT, 0, 32'h144 - 32'(4 * j));
      ex("t3_cc", K_CC, 0, DEPTH - 1 - j);
      step();
    end
    drive(3'b001, 3'b000, 3'b001, 0, 0, 0);
    ex("t3_upv", K_PV, 0, 0);
    ex("t3_ucc", K_CC, 0, 0);
    ex("t3_ucp", K_CP, 0, 2);
    step();

    // checkpoint and recover
    do_reset();
    drive(3'b001, 3'b001, 3'b000, 32'hA0, 0, 0);
    ex("t4_cp", K_CP, 0, 1);
    ex("t4_cc", K_CC, 0, 1);
    ex("t4_ct", K_CT, 0, 32'hA0);
    step();
    drive(3'b111, 3'b001, 3'b110, 32'hB0, 0, 0);
    ex("t4_pt1", K_PT, 1, 32'hB0);
    ex("t4_pt2", K_PT, 2, 32'hA0);
    ex("t4_cc2", K_CC, 2, 0);
    step();
    recover_en  = 1'b1;
    recover_ptr = 4'd1;
    recover_cnt = 5'd1;
    recover_top = 32'hA0;
    ex("t4_rcc", K_CC, 0, 0);
    step();
    drive(3'b001, 3'b000, 3'b001, 0, 0, 0);
    ex("t4_pv", K_PV, 0, 1);
    ex("t4_pt", K_PT, 0, 32'hA0);
    ex("t4_cc0", K_CC, 0, 0);
    step();

    // coroutine: push and pop in one slot
    do_reset();
    drive(3'b001, 3'b001, 3'b000, 32'h20, 0, 0);
    step();
    drive(3'b001, 3'b001, 3'b001, 32'h30, 0, 0);
    ex("t5_pv", K_PV, 0, 1);
    ex("t5_pt", K_PT, 0, 32'h20);
    ex("t5_cc", K_CC, 0, 1);
    ex("t5_cp", K_CP, 0, 1);
    ex("t5_ct", K_CT, 0, 32'h30);
    step();
    ex("t5_itop", K_CT, 0, 32'h30);
    ex("t5_icnt", K_CC, 0, 1);
    step();

    // recover beats a same-cycle push
    drive(3'b001, 3'b001, 3'b000, 32'hFF, 0, 0);
    recover_en  = 1'b1;
    recover_ptr = 4'd5;
    recover_cnt = 5'd3;
    recover_top = 32'h55;
    ex("t6_pre", K_CT, 0, 32'hFF);
    ex("t6_prp", K_CP, 0, 2);
    step();
    drive(3'b001, 3'b000, 3'b001, 0, 0, 0);
    ex("t6_pv", K_PV, 0, 1);
    ex("t6_pt", K_PT, 0, 32'h55);
    ex("t6_cc", K_CC, 0, 2);
    ex("t6_cp", K_CP, 0, 4);
    step();

    // asynchronous reset mid-bundle
    drive(3'b111, 3'b000, 3'b111, 0, 0, 0);
    #2;
    chk("t7_pre", 32'(pred_valid), 32'h3);
    reset = 1'b0;
    #1;
    chk("t7_pv", 32'(pred_valid), 32'h0);
    chk("t7_cc", 32'(ckpt_cnt[0]), 32'h0);
    chk("t7_cp", 32'(ckpt_ptr[2]), 32'h0);
    ex("t7_npv", K_PV, 0, 0);
    step();
    reset = 1'b1;

    if (sb.size() != 0)
      chk("sb_left", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ras_predictor.md
Name: ras_predictor

Overview:
- Parametrised, N-wide return address stack (RAS) that sits beside the branch predictor in the fetch stage.
- Fetch marks each slot as a call (push) and/or a return (pop). The block supplies the predicted return target for every return slot.
- Each slot also gets a checkpoint of the stack state. EX uses this checkpoint to repair the stack on a mispredict.
- Successor to the single-level JAL/JALR handling in BP. Adds multi-entry circular storage, in-bundle forwarding and speculative recovery.

Parameters:
N, 3, fetch/predict slots per cycle
DEPTH, 16, stack entries (power of two, ≥4)
XLEN, 32, address width
PTR_W, $clog2(DEPTH), top-of-stack pointer width
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
fetch_valid  in  N  slot i holds a valid instruction
push_en  in  N  slot i is a call (JAL/JALR with rd ∈ {x1,x5})
pop_en  in  N  slot i is a return (JALR with rs1 ∈ {x1,x5}, rs1≠rd)
push_addr  in  N×XLEN  return address for slot i (PC+4)
pred_valid  out  N  pred_target[i] is meaningful
pred_target  out  N×XLEN  predicted return target for slot i
ckpt_ptr  out  N×PTR_W  TOS pointer after slot i is applied
ckpt_cnt  out  N×CNT_W  occupancy after slot i is applied
ckpt_top  out  N×XLEN  TOS entry value after slot i is applied
recover_en  in  1  EX mispredict repair
recover_ptr  in  PTR_W  pointer to restore
recover_cnt  in  CNT_W  occupancy to restore
recover_top  in  XLEN  value written to stack[recover_ptr]

Behaviour:
- State:
  - stack[DEPTH] of XLEN bits.
  - tos_ptr (index of the current top entry).
  - count, saturating at DEPTH.
- Reset (reset=0, asynchronous):
  - tos_ptr=0, count=0, all entries 0.
  - All outputs are combinational from state, so at reset pred_valid=0, pred_target=0, ckpt_ptr=0, ckpt_cnt=0, ckpt_top=0.
- Slot processing is combinational and in order, slot 0 → N-1. Each slot sees the state left by the earlier slots of the same cycle (in-bundle forwarding). Slots with fetch_valid=0 have no effect.
- Pop (pop_en & fetch_valid):
  - If count>0: pred_valid=1, pred_target=top; then ptr←ptr−1 mod DEPTH, count←count−1.
  - If count=0: pred_valid=0, pred_target=0; ptr and count unchanged (underflow is not an error).
- Push (push_en & fetch_valid): ptr←ptr+1 mod DEPTH, stack[ptr]←push_addr, count←min(count+1, DEPTH).
  - When full, the push overwrites the oldest entry through wrap-around.
- Push and pop on the same slot (coroutine): the pop is applied first (its target is the old top), then the push.
- pred_valid[i]=0 for any slot without an effective pop.
- ckpt_* for slot i reflect the state after slot i's own operation.
- Sequential update: the final state after slot N-1 is written on the rising edge of clock. Multiple pushes in one cycle write distinct successive entries.
- Recovery: recover_en=1 at the clock edge loads tos_ptr←recover_ptr, count←recover_cnt, stack[recover_ptr]←recover_top.
  - All fetch-side pushes and pops that cycle are discarded.
  - Recovery has absolute priority over fetch.
  - Outputs during the recover cycle still reflect the pre-recover state. Fetch is squashed by the pipeline that cycle.
- Latency: prediction is the same cycle (combinational). State update is one cycle.
- Reset asserted mid-operation clears state immediately, regardless of recover_en or fetch inputs.

Test Plan:
- Reset, then a push in slot 1 (push_addr=0x8), next cycle a pop in slot 0 → pred_valid[0]=1, pred_target[0]=0x8; afterwards count=0. A further pop then gives pred_valid=0.
- One cycle with slot 0 push 0x14, slot 1 pop, slot 2 pop → pred_target[1]=0x14, pred_valid[2]=0, final count=0.
- DEPTH+2=18 pushes of 0x100+4k (k=0..17), then 16 pops → targets 0x144 down to 0x108, each valid. The 17th pop is invalid and count stays saturated correctly at 0.
- Push 0xA0, capture ckpt_* (ptr=1, cnt=1, top=0xA0). Push 0xB0 and pop twice (the second pop clobbers nothing). Apply recover with the captured values → next pop returns 0xA0.
- Same slot push 0x30 and pop with top=0x20 → pred_target=0x20; after the edge top=0x30 and count is unchanged.
- recover_en in the same cycle as a push of 0xFF → the push is ignored and the restored top is returned. Reset=0 asserted mid-run → pred_valid all 0 immediately.
